layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/nn_pkg.sv | 29 ++
 rtl/layer_sequencer_if.sv | 43 ++++
 rtl/nn_delay_line.sv | 29 ++
 rtl/layer_sequencer.sv | 154 +++++++++++++++
 tb/tb_layer_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the layer sequencer: FSM encoding and
// elaboration-time sizing helpers.
package nn_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_TRIGGER = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // RAM read latency supported by the drain logic.
  function automatic bit lat_ok(input int lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

  // True when a weight image of 'words' entries fits an aw-bit address.
  function automatic bit addr_fits(input int words, input int aw);
    return longint'(words) <= (longint'(1) << aw);
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Control/data bundle between the layer sequencer, weight RAM and units.
interface layer_sequencer_if
  import nn_pkg::*;
#(
  parameter int NUM_UNITS  = 4,
  parameter int NUM_INPUTS = 4,
  parameter int NUM_LAYERS = 2,
  parameter int ADDR_W     = 10,
  parameter int WEIGHT_W   = 8
);
  localparam int IW = idx_w(NUM_INPUTS);
  localparam int LW = idx_w(NUM_LAYERS);

  logic                  start;
  logic                  abort;
  logic [ADDR_W-1:0]     ram_addr;
  logic [31:0]           ram_data;
  logic [WEIGHT_W-1:0]   weight;
  logic [IW-1:0]         weight_addr;
  logic [NUM_UNITS-1:0]  weight_wr;
  logic                  sum_trigger;
  logic [NUM_UNITS-1:0]  unit_done;
  logic [LW-1:0]         layer;
  logic                  layer_sel;
  logic                  bank_write;
  logic                  busy;
  logic                  done;
  logic                  err;

  // Sequencer side.
  modport slave (
    input  start, abort, ram_data, unit_done,
    output ram_addr, weight, weight_addr, weight_wr, sum_trigger,
           layer, layer_sel, bank_write, busy, done, err
  );

  // Controller / environment side.
  modport master (
    output start, abort, ram_data, unit_done,
    input  ram_addr, weight, weight_addr, weight_wr, sum_trigger,
           layer, layer_sel, bank_write, busy, done, err
  );
endinterface

// File: rtl/nn_delay_line.sv
// Fixed-depth register delay line with synchronous flush.
module nn_delay_line
  import nn_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  // Shift d through DEPTH stages; flush drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else if (flush) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: streams weights from RAM into the units, fires the
// accumulation, waits for completion and steps through the layers.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_LAYERS  = 2,
  parameter int ADDR_W      = 10,
  parameter int WEIGHT_W    = 8,
  parameter int RAM_LATENCY = 1,
  parameter int TIMEOUT     = 1024
) (
  input logic              clk,
  input logic              reset,
  layer_sequencer_if.slave bus
);
  localparam int UW          = idx_w(NUM_UNITS);
  localparam int IW          = idx_w(NUM_INPUTS);
  localparam int LW          = idx_w(NUM_LAYERS);
  localparam int TW          = $clog2(TIMEOUT + 1);
  localparam int LAYER_WORDS = NUM_UNITS * NUM_INPUTS;
  localparam int DLW         = 1 + UW + IW;

  if (!lat_ok(RAM_LATENCY)) begin : g_lat_chk
    $error("layer_sequencer: RAM_LATENCY must be 1..4");
  end
  if (!addr_fits(NUM_LAYERS * LAYER_WORDS, ADDR_W)) begin : g_addr_chk
    $error("layer_sequencer: weight image does not fit ADDR_W");
  end

  logic [2:0]     state;
  logic [UW-1:0]  unit_cnt;
  logic [IW-1:0]  in_cnt;
  logic [2:0]     drain_cnt;
  logic [TW-1:0]  tcnt;
  logic [LW-1:0]  layer_q;
  logic           layer_sel_q;
  logic           run_active, kill, fetch_last, last_layer;

  assign run_active = (state == S_FETCH) || (state == S_DRAIN) || (state == S_TRIGGER) ||
                      (state == S_WAIT)  || (state == S_CAPTURE);
  assign kill       = run_active && bus.abort;
  assign fetch_last = (unit_cnt == UW'(NUM_UNITS - 1)) && (in_cnt == IW'(NUM_INPUTS - 1));
  assign last_layer = (layer_q == LW'(NUM_LAYERS - 1));

  // Run control FSM with fetch, drain and timeout counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      unit_cnt    <= '0;
      in_cnt      <= '0;
      drain_cnt   <= '0;
      tcnt        <= '0;
      layer_q     <= '0;
      layer_sel_q <= 1'b0;
    end else if (kill) begin
      state     <= S_IDLE;
      unit_cnt  <= '0;
      in_cnt    <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERROR: if (bus.start) begin
          state       <= S_FETCH;
          layer_q     <= '0;
          layer_sel_q <= 1'b0;
          unit_cnt    <= '0;
          in_cnt      <= '0;
        end
        S_FETCH: begin
          if (in_cnt == IW'(NUM_INPUTS - 1)) begin
            in_cnt   <= '0;
            unit_cnt <= (unit_cnt == UW'(NUM_UNITS - 1)) ? '0 : unit_cnt + 1'b1;
          end else begin
            in_cnt <= in_cnt + 1'b1;
          end
          if (fetch_last) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 3'(RAM_LATENCY - 1)) state <= S_TRIGGER;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        S_TRIGGER: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion wins over a timeout landing in the same cycle.
          if (&bus.unit_done) state <= S_CAPTURE;
          else if (tcnt == TW'(TIMEOUT - 1)) state <= S_ERROR;
          else tcnt <= tcnt + 1'b1;
        end
        S_CAPTURE: begin
          if (last_layer) begin
            state <= S_FINISH;
          end else begin
            layer_q     <= layer_q + 1'b1;
            layer_sel_q <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_addr = ADDR_W'(int'(layer_q) * LAYER_WORDS +
                                int'(unit_cnt) * NUM_INPUTS + int'(in_cnt));

  // Unit/slot tags travel alongside the RAM read so strobes line up with data.
  // Abort flushes what is still in flight; the write already presented in the
  // abort cycle has left the pipe and is not recalled.
  logic [DLW-1:0] dl_q;
  logic           dl_vld;
  logic [UW-1:0]  dl_unit;
  logic [IW-1:0]  dl_slot;

  nn_delay_line #(.DEPTH(RAM_LATENCY), .WIDTH(DLW)) u_align (
    .clk   (clk),
    .reset (reset),
    .flush (kill),
    .d     ({state == S_FETCH, unit_cnt, in_cnt}),
    .q     (dl_q)
  );

  assign {dl_vld, dl_unit, dl_slot} = dl_q;

  logic [NUM_UNITS-1:0] wr_dec;

  // One-hot write strobe for the unit whose weight is on the bus.
  always_comb begin
    wr_dec = '0;
    for (int u = 0; u < NUM_UNITS; u++) wr_dec[u] = dl_vld && (dl_unit == UW'(u));
  end

  logic unused_ram;
  assign unused_ram = ^bus.ram_data;

  assign bus.weight_wr   = wr_dec;
  assign bus.weight_addr = dl_slot;
  assign bus.weight      = dl_vld ? bus.ram_data[WEIGHT_W-1:0] : '0;
  assign bus.sum_trigger = (state == S_TRIGGER) && !bus.abort;
  assign bus.bank_write  = (state == S_CAPTURE) && !bus.abort;
  assign bus.done        = (state == S_FINISH);
  assign bus.err         = (state == S_ERROR);
  assign bus.busy        = run_active;
  assign bus.layer       = layer_q;
  assign bus.layer_sel   = layer_sel_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: three configurations, RAM models returning the
// address as data, responders raising unit_done 5 cycles after sum_trigger,
// and a scoreboard of expected weight writes per instance.
module tb_layer_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_sequencer_if #(.NUM_UNITS(4), .NUM_INPUTS(4), .NUM_LAYERS(2)) i0 ();
  layer_sequencer_if #(.NUM_UNITS(4), .NUM_INPUTS(4), .NUM_LAYERS(2)) i1 ();
  layer_sequencer_if #(.NUM_UNITS(8), .NUM_INPUTS(2), .NUM_LAYERS(3)) i2 ();

  layer_sequencer #(.RAM_LATENCY(1)) d0 (.clk(clk), .reset(reset), .bus(i0));
  layer_sequencer #(.RAM_LATENCY(3)) d1 (.clk(clk), .reset(reset), .bus(i1));
  layer_sequencer #(.NUM_UNITS(8), .NUM_INPUTS(2), .NUM_LAYERS(3)) d2 (
    .clk(clk), .reset(reset), .bus(i2));

  // Weight RAMs: word = address, latency matching each instance.
  logic [31:0] r0, r2;
  logic [31:0] r1p [3];
  always @(posedge clk) begin
    r0     <= 32'(i0.ram_addr);
    r2     <= 32'(i2.ram_addr);
    r1p[0] <= 32'(i1.ram_addr);
    r1p[1] <= r1p[0];
    r1p[2] <= r1p[1];
  end
  assign i0.ram_data = r0;
  assign i1.ram_data = r1p[2];
  assign i2.ram_data = r2;

  typedef struct {
    logic [31:0] wr;
    int slot;
    int w;
    int lay;
    int lsel;
  } exp_t;

  exp_t sb [3][$];
  int   bw [3] = '{0, 0, 0};
  int   dn [3] = '{0, 0, 0};
  int   trg [3] = '{0, 0, 0};
  int   lastwr [3] = '{-100, -100, -100};
  int   tcy [3] = '{0, 0, 0};
  bit   pend [3] = '{0, 0, 0};
  bit   force0 = 1'b0;
  logic [3:0] fval0 = 4'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic push(input int id, input int nu, input int ni, input int nl, input int count);
    exp_t e;
    int n = 0;
    for (int l = 0; l < nl; l++)
      for (int u = 0; u < nu; u++)
        for (int i = 0; i < ni; i++)
          if (n < count) begin
            e.wr   = 32'd1 << u;
            e.slot = i;
            e.w    = (l * nu * ni + u * ni + i) & 255;
            e.lay  = l;
            e.lsel = (l > 0) ? 1 : 0;
            sb[id].push_back(e);
            n++;
          end
  endtask

  task automatic check_wr(input int id, input logic [31:0] wr, input int slot, input int w,
                          input int lay, input int lsel);
    exp_t e;
    if (sb[id].size() == 0) begin
      chk("wr_unexpected", 64'(wr), 64'd0);
    end else begin
      e = sb[id].pop_front();
      chk("wr_unit",   64'(wr),   64'(e.wr));
      chk("wr_slot",   64'(slot), 64'(e.slot));
      chk("wr_weight", 64'(w),    64'(e.w));
      chk("wr_layer",  64'(lay),  64'(e.lay));
      chk("wr_lsel",   64'(lsel), 64'(e.lsel));
    end
  endtask

  // Per-instance monitor and unit_done responder bookkeeping.
  task automatic observe(input int id, input logic [31:0] wr, input int slot, input int w,
                         input int lay, input int lsel, input bit trig, input bit bwr,
                         input bit dni, output bit set_o, output bit clr_o);
    set_o = 1'b0;
    clr_o = 1'b0;
    if (wr != 0) begin
      lastwr[id] = cyc;
      check_wr(id, wr, slot, w, lay, lsel);
    end
    if (trig) begin
      trg[id]++;
      chk("drain_gap", 64'(cyc - lastwr[id]), 64'd1);
      pend[id] = 1'b1;
      tcy[id]  = cyc;
    end
    if (bwr) begin
      bw[id]++;
      clr_o = 1'b1;
    end
    if (dni) dn[id]++;
    if (pend[id] && cyc == tcy[id] + 5) begin
      pend[id] = 1'b0;
      set_o    = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    bit s, c;
    if (reset) begin
      pend = '{0, 0, 0};
      i0.unit_done = '0;
      i1.unit_done = '0;
      i2.unit_done = '0;
    end else begin
      observe(0, 32'(i0.weight_wr), int'(i0.weight_addr), int'(i0.weight), int'(i0.layer),
              int'(i0.layer_sel), i0.sum_trigger, i0.bank_write, i0.done, s, c);
      if (c) i0.unit_done = '0;
      if (s) i0.unit_done = '1;
      if (force0) i0.unit_done = fval0;
      observe(1, 32'(i1.weight_wr), int'(i1.weight_addr), int'(i1.weight), int'(i1.layer),
              int'(i1.layer_sel), i1.sum_trigger, i1.bank_write, i1.done, s, c);
      if (c) i1.unit_done = '0;
      if (s) i1.unit_done = '1;
      observe(2, 32'(i2.weight_wr), int'(i2.weight_addr), int'(i2.weight), int'(i2.layer),
              int'(i2.layer_sel), i2.sum_trigger, i2.bank_write, i2.done, s, c);
      if (c) i2.unit_done = '0;
      if (s) i2.unit_done = '1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int id, input int base);
    int n = 0;
    while (dn[id] == base && n < 3000) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(dn[id]), 64'(base + 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b;
    reset = 1'b1;
    i0.start = 0; i0.abort = 0;
    i1.start = 0; i1.abort = 0;
    i2.start = 0; i2.abort = 0;
    tick(3);
    chk("rst_busy",  64'(i0.busy), 64'd0);
    chk("rst_err",   64'(i0.err), 64'd0);
    chk("rst_done",  64'(i0.done), 64'd0);
    chk("rst_wr",    64'(i0.weight_wr), 64'd0);
    chk("rst_addr",  64'(i0.ram_addr), 64'd0);
    chk("rst_trig",  64'(i0.sum_trigger), 64'd0);
    chk("rst_bank",  64'(i0.bank_write), 64'd0);
    chk("rst_layer", 64'(i0.layer), 64'd0);
    chk("rst_lsel",  64'(i0.layer_sel), 64'd0);
    reset = 1'b0;
    tick();

    // Default config, two-layer run; a start during the run is ignored.
    push(0, 4, 4, 2, 32);
    i0.start = 1; tick(); i0.start = 0;
    chk("run_busy", 64'(i0.busy), 64'd1);
    chk("run_addr0", 64'(i0.ram_addr), 64'd0);
    tick(3);
    i0.start = 1; tick(); i0.start = 0;
    wait_done(0, 0);
    chk("fin_done",  64'(i0.done), 64'd1);
    chk("fin_busy",  64'(i0.busy), 64'd0);
    chk("fin_layer", 64'(i0.layer), 64'd1);
    chk("fin_lsel",  64'(i0.layer_sel), 64'd1);
    tick();
    chk("done_pulse", 64'(i0.done), 64'd0);
    chk("hold_layer", 64'(i0.layer), 64'd1);
    tick(2);
    chk("sb0_empty", 64'(sb[0].size()), 64'd0);
    chk("bw0", 64'(bw[0]), 64'd2);
    chk("trg0", 64'(trg[0]), 64'd2);

    // RAM_LATENCY = 3.
    push(1, 4, 4, 2, 32);
    i1.start = 1; tick(); i1.start = 0;
    wait_done(1, 0);
    tick(2);
    chk("sb1_empty", 64'(sb[1].size()), 64'd0);
    chk("bw1", 64'(bw[1]), 64'd2);
    chk("trg1", 64'(trg[1]), 64'd2);

    // 8 units x 2 inputs x 3 layers.
    push(2, 8, 2, 3, 48);
    i2.start = 1; tick(); i2.start = 0;
    wait_done(2, 0);
    chk("fin2_layer", 64'(i2.layer), 64'd2);
    tick(2);
    chk("sb2_empty", 64'(sb[2].size()), 64'd0);
    chk("bw2", 64'(bw[2]), 64'd3);
    chk("dn2", 64'(dn[2]), 64'd1);

    // Timeout with unit_done stuck at 0111, then restart from ERROR.
    force0 = 1'b1;
    fval0  = 4'b0111;
    push(0, 4, 4, 2, 16);
    i0.start = 1; tick(); i0.start = 0;
    n = 0;
    while (!i0.sum_trigger && n < 100) begin
      tick();
      n++;
    end
    chk("to_trig", 64'(i0.sum_trigger), 64'd1);
    tick(1024);
    chk("to_err_pre",  64'(i0.err), 64'd0);
    chk("to_busy_pre", 64'(i0.busy), 64'd1);
    tick();
    chk("to_err",  64'(i0.err), 64'd1);
    chk("to_busy", 64'(i0.busy), 64'd0);
    tick(5);
    chk("to_sticky", 64'(i0.err), 64'd1);
    fval0 = 4'b0;
    tick();
    force0 = 1'b0;
    b = dn[0];
    push(0, 4, 4, 2, 32);
    i0.start = 1; tick(); i0.start = 0;
    chk("re_err",  64'(i0.err), 64'd0);
    chk("re_busy", 64'(i0.busy), 64'd1);
    chk("re_addr", 64'(i0.ram_addr), 64'd0);
    wait_done(0, b);
    tick(2);
    chk("re_sb_empty", 64'(sb[0].size()), 64'd0);

    // Abort on the 7th FETCH cycle.
    b = dn[0];
    n = bw[0];
    push(0, 4, 4, 2, 6);
    i0.start = 1; tick(); i0.start = 0;
    tick(6);
    chk("ab_addr", 64'(i0.ram_addr), 64'd6);
    i0.abort = 1; tick(); i0.abort = 0;
    chk("ab_busy", 64'(i0.busy), 64'd0);
    tick(10);
    chk("ab_sb_empty", 64'(sb[0].size()), 64'd0);
    chk("ab_no_done", 64'(dn[0]), 64'(b));
    chk("ab_no_bank", 64'(bw[0]), 64'(n));

    // Asynchronous reset in WAIT_DONE of layer 1, then a clean run.
    push(0, 4, 4, 2, 32);
    b = bw[0];
    i0.start = 1; tick(); i0.start = 0;
    n = 0;
    while (bw[0] == b && n < 300) begin
      tick();
      n++;
    end
    n = 0;
    while (!i0.sum_trigger && n < 300) begin
      tick();
      n++;
    end
    tick(2);
    chk("pre_rst_layer", 64'(i0.layer), 64'd1);
    chk("pre_rst_busy",  64'(i0.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy",  64'(i0.busy), 64'd0);
    chk("arst_layer", 64'(i0.layer), 64'd0);
    chk("arst_lsel",  64'(i0.layer_sel), 64'd0);
    chk("arst_addr",  64'(i0.ram_addr), 64'd0);
    chk("arst_err",   64'(i0.err), 64'd0);
    tick(2);
    reset = 1'b0;
    tick();
    chk("arst_sb_empty", 64'(sb[0].size()), 64'd0);
    b = dn[0];
    n = bw[0];
    push(0, 4, 4, 2, 32);
    i0.start = 1; tick(); i0.start = 0;
    wait_done(0, b);
    tick(2);
    chk("post_sb_empty", 64'(sb[0].size()), 64'd0);
    chk("post_bank", 64'(bw[0] - n), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
